// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - AES SubBytes/InvSubBytes engine, LANES bytes per beat over a shared GF(2^8) inverter
module sub_bytes_engine #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);
    localparam int BEATS = 16 / LANES;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic            armed;
    logic            mode;
    logic [CW-1:0]   beat;
    logic [127:0]    work, work_next;
    logic            accept, last_beat;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic m);
        return m ? gf_inv(inv_affine(x)) : affine(gf_inv(x));
    endfunction

    always_comb begin
        work_next = work;
        for (int l = 0; l < LANES; l++) begin
            work_next[(int'(beat) * LANES + l) * 8 +: 8] = sbox(work[(int'(beat) * LANES + l) * 8 +: 8], mode);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = armed && (state == IDLE);
        out_valid  = (state == DONE);
        accept     = in_ready && in_valid;
        last_beat  = (beat == LAST);
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = RUN;
                RUN:     if (last_beat) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // armed holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed    <= 1'b0;
            mode     <= 1'b0;
            beat     <= '0;
            work     <= '0;
            data_out <= '0;
        end else begin
            armed <= 1'b1;
            if (abort) begin
                beat <= '0;
            end else if (state == IDLE) begin
                if (accept) begin
                    work <= data_in;
                    mode <= inv;
                    beat <= '0;
                end
            end else if (state == RUN) begin
                work <= work_next;
                if (last_beat) begin
                    data_out <= work_next;
                    beat     <= '0;
                end else begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end
endmodule
